// File: rtl/otter_cu_fsm_if.sv
// rtl/otter_cu_fsm_if.sv - instruction/memory/interrupt inputs and control strobes of the OTTER control FSM
interface otter_cu_fsm_if;
    logic [6:0] ir_opcode;
    logic [2:0] ir_funct;
    logic       mem_rdy;
    logic       intr;
    logic       mie;
    logic       pc_write;
    logic       reg_write;
    logic       csr_we;
    logic       mem_rden1;
    logic       mem_rden2;
    logic       mem_we2;
    logic       mret_exec;
    logic       int_taken;
    logic       illegal;
    logic       bus_err;
    logic [2:0] state;

    modport master (
        input  ir_opcode, ir_funct, mem_rdy, intr, mie,
        output pc_write, reg_write, csr_we, mem_rden1, mem_rden2, mem_we2,
               mret_exec, int_taken, illegal, bus_err, state
    );

    modport slave (
        output ir_opcode, ir_funct, mem_rdy, intr, mie,
        input  pc_write, reg_write, csr_we, mem_rden1, mem_rden2, mem_we2,
               mret_exec, int_taken, illegal, bus_err, state
    );
endinterface

// File: rtl/otter_cu_fsm.sv
// rtl/otter_cu_fsm.sv - OTTER multicycle control FSM; define CU_FSM_INTR_EN to enable interrupt entry
module otter_cu_fsm #(
    parameter int INIT_CYCLES = 1,
    parameter int WAIT_LIMIT  = 16
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    otter_cu_fsm_if.master  bus
);

    typedef enum logic [2:0] {
        S_INIT  = 3'd0,
        S_FETCH = 3'd1,
        S_EXEC  = 3'd2,
        S_WB    = 3'd3,
        S_INTR  = 3'd4
    } state_e;

    localparam int IW = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
    localparam int SW = (WAIT_LIMIT > 0) ? $clog2(WAIT_LIMIT + 1) : 1;
    localparam logic [IW-1:0] INIT_LAST = IW'(INIT_CYCLES - 1);
    localparam logic [SW-1:0] STALL_LIM = SW'(WAIT_LIMIT);

    state_e          state_q, state_d;
    logic [IW-1:0]   init_cnt_q, init_cnt_d;
    logic [SW-1:0]   stall_cnt_q, stall_cnt_d;

    logic is_alu, is_branch, is_store, is_load, is_sys;
    logic mem_op, timeout, intr_go;
    state_e done_next;

    always_comb begin
        is_alu    = 1'b0;
        is_branch = 1'b0;
        is_store  = 1'b0;
        is_load   = 1'b0;
        is_sys    = 1'b0;
        case (bus.ir_opcode)
            7'b0110011, 7'b0010011, 7'b0110111,
            7'b0010111, 7'b1101111, 7'b1100111: is_alu    = 1'b1;
            7'b1100011:                         is_branch = 1'b1;
            7'b0100011:                         is_store  = 1'b1;
            7'b0000011:                         is_load   = 1'b1;
            7'b1110011:                         is_sys    = 1'b1;
            default: ;
        endcase
    end

    assign mem_op  = is_load | is_store;
    // Ready on the limit cycle still completes normally, so timeout requires mem_rdy low.
    assign timeout = (WAIT_LIMIT != 0) && mem_op && !bus.mem_rdy && (stall_cnt_q == STALL_LIM);

`ifdef CU_FSM_INTR_EN
    assign intr_go = bus.intr & bus.mie;
`else
    logic unused_intr;
    assign unused_intr = bus.intr ^ bus.mie;
    assign intr_go     = 1'b0;
`endif

    assign done_next = intr_go ? S_INTR : S_FETCH;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= S_INIT;
            init_cnt_q  <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            init_cnt_q  <= init_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        init_cnt_d  = '0;
        stall_cnt_d = stall_cnt_q;
        case (state_q)
            S_INIT: begin
                if (init_cnt_q == INIT_LAST) begin
                    state_d = S_FETCH;
                end else begin
                    init_cnt_d = init_cnt_q + 1'b1;
                end
            end
            S_FETCH: begin
                state_d     = S_EXEC;
                stall_cnt_d = '0;
            end
            S_EXEC: begin
                if (!mem_op) begin
                    state_d = done_next;
                end else if (bus.mem_rdy) begin
                    state_d = is_load ? S_WB : done_next;
                end else if (timeout) begin
                    state_d = done_next;
                end else if (stall_cnt_q != '1) begin
                    stall_cnt_d = stall_cnt_q + 1'b1;
                end
            end
            S_WB:   state_d = done_next;
            S_INTR: state_d = S_FETCH;
            default: begin
                state_d     = S_INIT;
                stall_cnt_d = '0;
            end
        endcase
    end

    always_comb begin
        bus.pc_write  = 1'b0;
        bus.reg_write = 1'b0;
        bus.csr_we    = 1'b0;
        bus.mem_rden1 = 1'b0;
        bus.mem_rden2 = 1'b0;
        bus.mem_we2   = 1'b0;
        bus.mret_exec = 1'b0;
        bus.int_taken = 1'b0;
        bus.illegal   = 1'b0;
        bus.bus_err   = 1'b0;
        bus.state     = state_q;
        case (state_q)
            S_INIT: ;
            S_FETCH: bus.mem_rden1 = 1'b1;
            S_EXEC: begin
                if (is_alu) begin
                    bus.reg_write = 1'b1;
                    bus.pc_write  = 1'b1;
                end else if (is_branch) begin
                    bus.pc_write  = 1'b1;
                end else if (timeout) begin
                    bus.bus_err   = 1'b1;
                    bus.pc_write  = 1'b1;
                end else if (is_store) begin
                    bus.mem_we2   = 1'b1;
                    bus.pc_write  = bus.mem_rdy;
                end else if (is_load) begin
                    bus.mem_rden2 = 1'b1;
                end else if (is_sys) begin
                    bus.pc_write  = 1'b1;
                    if (bus.ir_funct == 3'b000) begin
                        bus.mret_exec = 1'b1;
                    end else begin
                        bus.csr_we    = 1'b1;
                        bus.reg_write = 1'b1;
                    end
                end else begin
                    bus.illegal  = 1'b1;
                    bus.pc_write = 1'b1;
                end
            end
            S_WB: begin
                bus.reg_write = 1'b1;
                bus.pc_write  = 1'b1;
            end
            S_INTR: begin
`ifdef CU_FSM_INTR_EN
                bus.int_taken = 1'b1;
                bus.pc_write  = 1'b1;
`endif
            end
            default: bus.state = S_INIT;
        endcase
    end

endmodule

// File: tb/tb_otter_cu_fsm.sv
// tb/tb_otter_cu_fsm.sv - self-checking bench for otter_cu_fsm with an instruction-level reference model
module tb_otter_cu_fsm;

    localparam int INIT_CYCLES = 2;
    localparam int WAIT_LIMIT  = 4;
`ifdef CU_FSM_INTR_EN
    localparam bit INTR_EN = 1'b1;
`else
    localparam bit INTR_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    otter_cu_fsm_if bus_if ();

    otter_cu_fsm #(.INIT_CYCLES(INIT_CYCLES), .WAIT_LIMIT(WAIT_LIMIT)) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus_if)
    );

    always #5 clk = ~clk;

    // Vector layout: {state[2:0], pc_write, reg_write, csr_we, rden1, rden2, we2, mret, int_taken, illegal, bus_err}
    function automatic logic [12:0] ev(input int st, input bit pcw, input bit rw, input bit csr,
                                       input bit r1, input bit r2, input bit we, input bit mret,
                                       input bit it, input bit ill, input bit be);
        return {3'(st), pcw, rw, csr, r1, r2, we, mret, it, ill, be};
    endfunction

    function automatic logic [12:0] observed();
        return {bus_if.state, bus_if.pc_write, bus_if.reg_write, bus_if.csr_we, bus_if.mem_rden1,
                bus_if.mem_rden2, bus_if.mem_we2, bus_if.mret_exec, bus_if.int_taken,
                bus_if.illegal, bus_if.bus_err};
    endfunction

    task automatic check(input logic [12:0] exp, input string name);
        logic [12:0] got;
        got = observed();
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, got, exp);
        end
    endtask

    task automatic step(input logic [6:0] op, input logic [2:0] f, input bit rdy, input bit it,
                        input bit mi, input logic [12:0] exp, input string name);
        @(negedge clk);
        bus_if.ir_opcode = op;
        bus_if.ir_funct  = f;
        bus_if.mem_rdy   = rdy;
        bus_if.intr      = it;
        bus_if.mie       = mi;
        #1;
        check(exp, name);
    endtask

    function automatic bit rb();
        return 1'($urandom_range(0, 1));
    endfunction

    // 0 alu/jump, 1 branch, 2 store, 3 load, 4 system, 5 illegal
    function automatic int op_class(input logic [6:0] op);
        case (op)
            7'b0110011, 7'b0010011, 7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111: return 0;
            7'b1100011: return 1;
            7'b0100011: return 2;
            7'b0000011: return 3;
            7'b1110011: return 4;
            default:    return 5;
        endcase
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        step(7'h33, 3'd0, rb(), rb(), rb(), ev(0,0,0,0,0,0,0,0,0,0,0), "reset_hold");
        step(7'h03, 3'd2, rb(), rb(), rb(), ev(0,0,0,0,0,0,0,0,0,0,0), "reset_hold");
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check(ev(0,0,0,0,0,0,0,0,0,0,0), "init_cycle1");
        step(7'h33, 3'd0, 1'b0, 1'b0, 1'b0, ev(0,0,0,0,0,0,0,0,0,0,0), "init_cycle2");
    endtask

    // Whole-instruction model: nstall = cycles MEM_RDY stays low before rising; ic/mc = INTR/MIE at completion.
    task automatic run_instr(input logic [6:0] op, input logic [2:0] f, input int nstall,
                             input bit ic, input bit mc, input string name);
        int  cls;
        int  stalls;
        bit  abort;
        cls = op_class(op);
        step(op, f, rb(), rb(), rb(), ev(1,0,0,0,1,0,0,0,0,0,0), {name, "_fetch"});
        case (cls)
            0: step(op, f, rb(), ic, mc, ev(2,1,1,0,0,0,0,0,0,0,0), {name, "_exec"});
            1: step(op, f, rb(), ic, mc, ev(2,1,0,0,0,0,0,0,0,0,0), {name, "_exec"});
            4: begin
                if (f == 3'b000) step(op, f, rb(), ic, mc, ev(2,1,0,0,0,0,0,1,0,0,0), {name, "_mret"});
                else             step(op, f, rb(), ic, mc, ev(2,1,1,1,0,0,0,0,0,0,0), {name, "_csr"});
            end
            5: step(op, f, rb(), ic, mc, ev(2,1,0,0,0,0,0,0,0,1,0), {name, "_illegal"});
            default: begin
                abort  = (WAIT_LIMIT != 0) && (nstall > WAIT_LIMIT);
                stalls = abort ? WAIT_LIMIT : nstall;
                for (int i = 0; i < stalls; i++) begin
                    step(op, f, 1'b0, rb(), rb(), ev(2,0,0,0,0,cls == 3,cls == 2,0,0,0,0), {name, "_stall"});
                end
                if (abort) begin
                    step(op, f, 1'b0, ic, mc, ev(2,1,0,0,0,0,0,0,0,0,1), {name, "_timeout"});
                end else if (cls == 2) begin
                    step(op, f, 1'b1, ic, mc, ev(2,1,0,0,0,0,1,0,0,0,0), {name, "_store_done"});
                end else begin
                    step(op, f, 1'b1, rb(), rb(), ev(2,0,0,0,0,1,0,0,0,0,0), {name, "_load_done"});
                    step(op, f, rb(), ic, mc, ev(3,1,1,0,0,0,0,0,0,0,0), {name, "_wb"});
                end
            end
        endcase
        if (INTR_EN && ic && mc) begin
            step(op, f, rb(), rb(), rb(), ev(4,1,0,0,0,0,0,0,1,0,0), {name, "_intr"});
        end
    endtask

    typedef struct {
        logic [6:0]  op;
        logic [2:0]  f;
        logic [12:0] exp;
        string       name;
    } vec_t;

    vec_t tbl[10];

    logic [6:0] legal_ops[10] = '{7'b0110011, 7'b0010011, 7'b0110111, 7'b0010111, 7'b1101111,
                                  7'b1100111, 7'b1100011, 7'b0100011, 7'b0000011, 7'b1110011};

    initial begin
        logic [6:0] op;
        logic [2:0] f;
        bus_if.ir_opcode = '0;
        bus_if.ir_funct  = '0;
        bus_if.mem_rdy   = 1'b0;
        bus_if.intr      = 1'b0;
        bus_if.mie       = 1'b0;

        tbl[0] = '{7'b0110011, 3'd0, ev(2,1,1,0,0,0,0,0,0,0,0), "add"};
        tbl[1] = '{7'b0010011, 3'd0, ev(2,1,1,0,0,0,0,0,0,0,0), "addi"};
        tbl[2] = '{7'b0110111, 3'd5, ev(2,1,1,0,0,0,0,0,0,0,0), "lui"};
        tbl[3] = '{7'b0010111, 3'd2, ev(2,1,1,0,0,0,0,0,0,0,0), "auipc"};
        tbl[4] = '{7'b1101111, 3'd7, ev(2,1,1,0,0,0,0,0,0,0,0), "jal"};
        tbl[5] = '{7'b1100111, 3'd0, ev(2,1,1,0,0,0,0,0,0,0,0), "jalr"};
        tbl[6] = '{7'b1100011, 3'd1, ev(2,1,0,0,0,0,0,0,0,0,0), "bne"};
        tbl[7] = '{7'b1110011, 3'd1, ev(2,1,1,1,0,0,0,0,0,0,0), "csrrw"};
        tbl[8] = '{7'b1110011, 3'd0, ev(2,1,0,0,0,0,0,1,0,0,0), "mret"};
        tbl[9] = '{7'b0000000, 3'd0, ev(2,1,0,0,0,0,0,0,0,1,0), "op_zero"};

        do_reset();

        for (int i = 0; i < 10; i++) begin
            step(tbl[i].op, tbl[i].f, 1'b0, 1'b0, 1'b0, ev(1,0,0,0,1,0,0,0,0,0,0), {tbl[i].name, "_fetch"});
            step(tbl[i].op, tbl[i].f, 1'b0, 1'b0, 1'b0, tbl[i].exp, {tbl[i].name, "_exec"});
        end

        run_instr(7'b0000011, 3'd2, 3, 1'b0, 1'b0, "lw_stall3");
        run_instr(7'b0100011, 3'd2, 20, 1'b0, 1'b0, "sw_timeout");
        run_instr(7'b0000011, 3'd2, WAIT_LIMIT, 1'b0, 1'b0, "lw_ready_at_limit");
        run_instr(7'b0010011, 3'd0, 0, 1'b1, 1'b1, "addi_intr");
        run_instr(7'b0010011, 3'd0, 0, 1'b1, 1'b0, "addi_mie0");
        run_instr(7'b0000011, 3'd2, 2, 1'b1, 1'b1, "lw_intr_wb");

        step(7'b0000011, 3'd2, 1'b0, 1'b0, 1'b0, ev(1,0,0,0,1,0,0,0,0,0,0), "midload_fetch");
        step(7'b0000011, 3'd2, 1'b0, 1'b0, 1'b0, ev(2,0,0,0,0,1,0,0,0,0,0), "midload_stall");
        step(7'b0000011, 3'd2, 1'b0, 1'b0, 1'b0, ev(2,0,0,0,0,1,0,0,0,0,0), "midload_stall");
        rst_n = 1'b0;
        #1;
        check(ev(0,0,0,0,0,0,0,0,0,0,0), "async_reset_midload");
        do_reset();

        for (int n = 0; n < 150; n++) begin
            if ($urandom_range(0, 7) == 0) op = 7'($urandom);
            else op = legal_ops[$urandom_range(0, 9)];
            f = 3'($urandom);
            run_instr(op, f, $urandom_range(0, 6), rb(), rb(), "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
